// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: FSM state encoding and command/timeout constants shared by adc_scan_ctrl
package adc_scan_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_TICK, ISSUE, WAIT_XFER, NEXT} scan_state_e;
  localparam logic [3:0] CMD_PREFIX = 4'b0001;
  localparam int TIMEOUT_CYCLES = 1023;
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: down-counter that emits a one-cycle tick every period+1 cycles while enabled
module scan_tick_gen #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    tick
);
  logic [PERIOD_WIDTH-1:0] cnt;
  assign tick = enable && cnt == '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else cnt <= (!enable || tick) ? period : cnt - 1'b1;
  end
endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: periodic masked ADC channel scan over an SPI master.
// Define ADC_SCAN_TIMEOUT_EN to add the 1023-cycle transfer timeout and the sticky tmo flag.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CH       = 8,
  parameter int CH_WIDTH     = 3,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    ovf_clr,
  output logic                    spi_start,
  output logic [DATA_WIDTH-1:0]   spi_data_in,
  input  logic [DATA_WIDTH-1:0]   spi_data_out,
  input  logic                    spi_busy,
  input  logic                    spi_new_data,
  output logic                    sample_valid,
  output logic [CH_WIDTH-1:0]     sample_ch,
  output logic [DATA_WIDTH-1:0]   sample_data,
  output logic                    scan_done,
  output logic                    ovf
`ifdef ADC_SCAN_TIMEOUT_EN
  , output logic                  tmo
`endif
);
  scan_state_e state;
  logic tick, overrun, halt, first_ok, nxt_ok;
  logic [CH_WIDTH-1:0] ch, first_ch, nxt_ch;
  logic [NUM_CH-1:0] mask_r;
`ifdef ADC_SCAN_TIMEOUT_EN
  logic [9:0] tcnt;
`endif

  scan_tick_gen #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_tick (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .tick(tick)
  );

  assign overrun = tick && (state == ISSUE || state == WAIT_XFER || state == NEXT);

  // descending scan so the lowest qualifying index wins
  always_comb begin
    first_ch = '0;
    first_ok = 1'b0;
    nxt_ch = '0;
    nxt_ok = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_mask[k]) begin
        first_ch = CH_WIDTH'(k);
        first_ok = 1'b1;
      end
      if (mask_r[k] && k > int'(ch)) begin
        nxt_ch = CH_WIDTH'(k);
        nxt_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ch <= '0;
      mask_r <= '0;
      halt <= 1'b0;
      spi_start <= 1'b0;
      spi_data_in <= '0;
      sample_valid <= 1'b0;
      sample_ch <= '0;
      sample_data <= '0;
      scan_done <= 1'b0;
      ovf <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
      tmo <= 1'b0;
      tcnt <= '0;
`endif
    end else begin
      spi_start <= 1'b0;
      sample_valid <= 1'b0;
      scan_done <= 1'b0;
      ovf <= overrun | (ovf & ~ovf_clr);
`ifdef ADC_SCAN_TIMEOUT_EN
      if (ovf_clr) tmo <= 1'b0;
`endif
      case (state)
        IDLE: state <= enable ? WAIT_TICK : IDLE;
        WAIT_TICK: begin
          if (!enable) state <= IDLE;
          else if (tick) begin
            mask_r <= ch_mask;
            ch <= first_ch;
            scan_done <= !first_ok;
            state <= first_ok ? ISSUE : WAIT_TICK;
          end
        end
        ISSUE: begin
          if (!enable) state <= IDLE;
          else if (!spi_busy) begin
            spi_start <= 1'b1;
            spi_data_in <= {CMD_PREFIX, 4'(ch), {(DATA_WIDTH-8){1'b0}}};
            state <= WAIT_XFER;
`ifdef ADC_SCAN_TIMEOUT_EN
            tcnt <= '0;
`endif
          end
        end
        WAIT_XFER: begin
          // an enable drop here is remembered so the transfer still finishes
          halt <= halt | ~enable;
          if (spi_new_data) begin
            sample_valid <= 1'b1;
            sample_ch <= ch;
            sample_data <= spi_data_out;
            state <= NEXT;
          end
`ifdef ADC_SCAN_TIMEOUT_EN
          else if (tcnt == 10'(TIMEOUT_CYCLES - 1)) begin
            tmo <= 1'b1;
            state <= NEXT;
          end else tcnt <= tcnt + 1'b1;
`endif
        end
        NEXT: begin
          halt <= 1'b0;
          if (halt || !enable) state <= IDLE;
          else if (nxt_ok) begin
            ch <= nxt_ch;
            state <= ISSUE;
          end else begin
            scan_done <= 1'b1;
            state <= WAIT_TICK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed bench for adc_scan_ctrl with a small SPI slave responder
`timescale 1ns/1ps
module tb_adc_scan_ctrl;
  import adc_scan_pkg::*;
  logic clk = 0, rst = 0, enable = 0, ovf_clr = 0;
  logic [7:0] ch_mask = 8'h00;
  logic [15:0] period = 16'd0;
  logic [15:0] spi_data_out = 16'hF0F0;
  logic spi_start, sample_valid, scan_done, ovf;
  logic [15:0] spi_data_in, sample_data;
  logic [2:0] sample_ch;
  logic sl_busy = 0, sl_nd = 0, busy_force = 0, stray = 0, slave_on = 1;
  logic spi_busy, spi_new_data;
`ifdef ADC_SCAN_TIMEOUT_EN
  logic tmo;
`endif
  int n_cmp = 0, n_err = 0, cyc = 0, n_start = 0, n_valid = 0, n_done = 0;
  int last_tick = 0, last_done = 0, done_gap = 0, done_int = 0, ovf_hi = 0, glitch = 0, scnt = 0;
  logic [15:0] starts[$];
  logic [2:0] chs[$];
  logic [15:0] vals[$];
  logic in_xfer = 0, prev_start = 0;
  logic [15:0] held = 16'h0;

  assign spi_busy = sl_busy | busy_force;
  assign spi_new_data = sl_nd | stray;

  adc_scan_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .period(period),
    .ovf_clr(ovf_clr), .spi_start(spi_start), .spi_data_in(spi_data_in),
    .spi_data_out(spi_data_out), .spi_busy(spi_busy), .spi_new_data(spi_new_data),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .scan_done(scan_done), .ovf(ovf)
`ifdef ADC_SCAN_TIMEOUT_EN
    , .tmo(tmo)
`endif
  );

  always #5 clk = ~clk;

  // observe first, then advance the slave so its strobes land mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (!rst) in_xfer = 0;
    if (spi_start) begin
      n_start++;
      starts.push_back(spi_data_in);
      in_xfer = 1;
      held = spi_data_in;
    end else if (in_xfer && spi_data_in !== held) glitch++;
    if (spi_start && prev_start) glitch++;
    prev_start = spi_start;
    if (spi_new_data) in_xfer = 0;
    if (sample_valid) begin
      n_valid++;
      chs.push_back(sample_ch);
      vals.push_back(sample_data);
    end
    if (scan_done) begin
      n_done++;
      done_gap = cyc - last_tick;
      done_int = cyc - last_done;
      last_done = cyc;
    end
    if (ovf) ovf_hi++;
    if (dut.tick) last_tick = cyc;
    sl_nd = 0;
    if (scnt > 0) begin
      scnt--;
      if (scnt == 0) begin
        sl_busy = 0;
        sl_nd = 1;
      end
    end else if (spi_start && slave_on) begin
      sl_busy = 1;
      scnt = 3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_state(input scan_state_e s, input string tag);
    int i = 0;
    while (dut.state !== s && i < 300) begin
      step(1);
      i++;
    end
    chk(tag, dut.state, s);
  endtask

  initial begin
    int b_start, b_valid, b_done;
    step(3);
    chk("rst_start", spi_start, 0);
    chk("rst_data_in", spi_data_in, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ch", sample_ch, 0);
    chk("rst_sdata", sample_data, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", dut.state, IDLE);
`ifdef ADC_SCAN_TIMEOUT_EN
    chk("rst_tmo", tmo, 0);
`endif
    rst = 1; ch_mask = 8'h05; period = 16'd999;
    step(2);
    enable = 1;
    step(1100);
    chk("s1_starts", n_start, 2);
    chk("s1_cmd0", starts[0], 16'h1000);
    chk("s1_cmd1", starts[1], 16'h1200);
    chk("s1_valid", n_valid, 2);
    chk("s1_ch0", chs[0], 0);
    chk("s1_ch1", chs[1], 2);
    chk("s1_data", vals[1], 16'hF0F0);
    chk("s1_done", n_done, 1);
    chk("s1_ovf", ovf, 0);
    step(1000);
    chk("s1_done2", n_done, 2);
    chk("s1_period", done_int, 1000);
    chk("s1_starts2", n_start, 4);
    chk("xfer_stable", glitch, 0);
    enable = 0;
    step(1);
    chk("drop_wait_tick", dut.state, IDLE);

    ch_mask = 8'h01; period = 16'd4; busy_force = 1;
    step(2);
    b_start = n_start; enable = 1;
    step(20);
    chk("busy_hold_start", n_start - b_start, 0);
    chk("busy_hold_state", dut.state, ISSUE);
    chk("ovf_set", ovf, 1);
    busy_force = 0;
    step(2);
    chk("busy_release", n_start - b_start, 1);
    enable = 0;
    step(10);
    chk("idle_before_clr", dut.state, IDLE);
    ovf_clr = 1;
    step(1);
    ovf_clr = 0;
    chk("ovf_clr", ovf, 0);

    ch_mask = 8'hFF; period = 16'd9;
    step(2);
    b_valid = n_valid; enable = 1;
    step(100);
    for (int k = 0; k < 8; k++) chk("scan8_ch", chs[b_valid + k], k);
    chk("scan8_ovf", ovf, 1);
    ovf_clr = 1;
    step(2);
    ovf_hi = 0;
    step(100);
    chk("ovf_clr_coincident", ovf_hi > 0, 1);
    ovf_clr = 0;

    wait_state(WAIT_XFER, "reach_xfer");
    enable = 0; b_valid = n_valid; b_done = n_done;
    step(12);
    chk("drop_valid", n_valid - b_valid, 1);
    chk("drop_done", n_done - b_done, 0);
    chk("drop_state", dut.state, IDLE);

    enable = 1;
    wait_state(WAIT_XFER, "reach_xfer2");
    rst = 0;
    #1;
    chk("arst_start", spi_start, 0);
    chk("arst_data_in", spi_data_in, 0);
    chk("arst_valid", sample_valid, 0);
    chk("arst_ch", sample_ch, 0);
    chk("arst_sdata", sample_data, 0);
    chk("arst_done", scan_done, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_state", dut.state, IDLE);
    enable = 0;
    step(2);
    rst = 1; b_valid = n_valid;
    step(3);
    stray = 1;
    step(1);
    stray = 0;
    step(6);
    chk("stray_valid", n_valid - b_valid, 0);
    chk("stray_state", dut.state, IDLE);

    ch_mask = 8'h00; period = 16'd9;
    step(2);
    b_start = n_start; b_done = n_done; enable = 1;
    step(55);
    chk("empty_start", n_start - b_start, 0);
    chk("empty_done", n_done - b_done, 5);
    chk("empty_interval", done_int, 10);
    chk("empty_after_tick", done_gap, 1);
    chk("xfer_stable_end", glitch, 0);

`ifdef ADC_SCAN_TIMEOUT_EN
    enable = 0; ch_mask = 8'h03; slave_on = 0; period = 16'd20;
    step(2);
    b_start = n_start; b_valid = n_valid; enable = 1;
    for (int i = 0; i < 100 && n_start == b_start; i++) step(1);
    chk("tmo_first_start", n_start - b_start, 1);
    step(1000);
    chk("tmo_early", tmo, 0);
    step(30);
    chk("tmo_set", tmo, 1);
    chk("tmo_next_issue", n_start - b_start, 2);
    chk("tmo_next_cmd", starts[starts.size() - 1], 16'h1100);
    chk("tmo_no_valid", n_valid - b_valid, 0);
    ovf_clr = 1;
    step(1);
    ovf_clr = 0;
    chk("tmo_clr", tmo, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
